// File: rtl/cyl_conv_pkg.sv
// Shared definitions for the cylindrical-converter arbiter.
// Holds the sequencer state enum, the default operand/result widths and converter latency,
// and a width helper for indices and counters.
package cyl_conv_pkg;

  localparam int unsigned X_W      = 4;
  localparam int unsigned Y_W      = 3;
  localparam int unsigned R_W      = 4;
  localparam int unsigned CONV_LAT = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Index width for n items; never below one bit so ports stay legal for n <= 2.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cyl_conv_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   valid_i - per-requester request valid
//   ptr_i   - highest-priority index for this pick
//   any_o   - at least one valid request
//   grant_o - one-hot grant (zero when nothing is valid)
//   idx_o   - encoded index of the granted requester
module cyl_conv_arbiter_rr_pick
  import cyl_conv_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic            any_o,
  output logic [NREQ-1:0] grant_o,
  output logic [IdW-1:0]  idx_o
);

  int unsigned j;

  // Scan offsets from farthest to nearest so the nearest valid index at or after ptr_i wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr_i) + (NREQ - 1 - k)) % NREQ;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IdW'(j);
      end
    end
    any_o = |valid_i;
  end

endmodule

// File: rtl/cyl_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered Cartesian-to-cylindrical converter.
// Accepts one (x, y) request at a time, pulses conv_ena once, waits CONV_LAT cycles,
// captures r/theta and returns them with the requester id on a valid/ready channel.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_x/req_y        - packed requester inputs
//   req_ready                    - one-hot accept, only ever high in IDLE
//   conv_ena/conv_x/conv_y       - converter enable pulse and held operands
//   conv_r/conv_theta            - converter results
//   rsp_valid/rsp_ready          - response handshake
//   rsp_id/rsp_r/rsp_theta       - response payload
//   busy                         - high whenever not IDLE
module cyl_conv_arbiter
  import cyl_conv_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned X_W      = cyl_conv_pkg::X_W,
  parameter int unsigned Y_W      = cyl_conv_pkg::Y_W,
  parameter int unsigned R_W      = cyl_conv_pkg::R_W,
  parameter int unsigned CONV_LAT = cyl_conv_pkg::CONV_LAT,
  localparam int unsigned IdW     = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*X_W-1:0] req_x,
  input  logic [NREQ*Y_W-1:0] req_y,
  output logic [NREQ-1:0]     req_ready,
  output logic              conv_ena,
  output logic [X_W-1:0]    conv_x,
  output logic [Y_W-1:0]    conv_y,
  input  logic [R_W-1:0]    conv_r,
  input  logic [R_W-1:0]    conv_theta,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IdW-1:0]    rsp_id,
  output logic [R_W-1:0]    rsp_r,
  output logic [R_W-1:0]    rsp_theta,
  output logic              busy
);

  localparam int unsigned CntW = id_width(CONV_LAT);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [R_W-1:0]  r_q, r_d;
  logic [R_W-1:0]  th_q, th_d;

  logic            pick_any;
  logic [NREQ-1:0] pick_grant;
  logic [IdW-1:0]  pick_idx;

  cyl_conv_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .any_o   (pick_any),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    id_d      = id_q;
    r_d       = r_q;
    th_d      = th_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          // Gate with rst so no transfer is signalled while reset is being applied.
          if (!rst) req_ready = pick_grant;
          x_d     = req_x[pick_idx*X_W +: X_W];
          y_d     = req_y[pick_idx*Y_W +: Y_W];
          id_d    = pick_idx;
          ptr_d   = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (32'(cnt_q) == CONV_LAT - 1) begin
          r_d     = conv_r;
          th_d    = conv_theta;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      id_q    <= '0;
      r_q     <= '0;
      th_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      id_q    <= id_d;
      r_q     <= r_d;
      th_q    <= th_d;
    end
  end

  assign conv_ena  = (state_q == StIssue);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign conv_x    = x_q;
  assign conv_y    = y_q;
  assign rsp_id    = id_q;
  assign rsp_r     = r_q;
  assign rsp_theta = th_q;

endmodule

// File: tb/tb_cyl_conv_arbiter.sv
// Self-checking bench for cyl_conv_arbiter with a registered converter model
// (r = |x - y|, theta = (x + y) >> 1) and a round-robin reference model.
module tb_cyl_conv_arbiter;

  localparam int NREQ = 4;
  localparam int X_W  = 4;
  localparam int Y_W  = 3;
  localparam int R_W  = 4;
  localparam int IdW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*X_W-1:0] req_x;
  logic [NREQ*Y_W-1:0] req_y;
  logic [NREQ-1:0]     req_ready;
  logic                conv_ena;
  logic [X_W-1:0]      conv_x;
  logic [Y_W-1:0]      conv_y;
  logic [R_W-1:0]      conv_r = '0;
  logic [R_W-1:0]      conv_theta = '0;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IdW-1:0]      rsp_id;
  logic [R_W-1:0]      rsp_r;
  logic [R_W-1:0]      rsp_theta;
  logic                busy;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  cyl_conv_arbiter #(
    .NREQ     (NREQ),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .R_W      (R_W),
    .CONV_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .conv_ena   (conv_ena),
    .conv_x     (conv_x),
    .conv_y     (conv_y),
    .conv_r     (conv_r),
    .conv_theta (conv_theta),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_theta  (rsp_theta),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [R_W-1:0] ref_r(input int x, input int y);
    return R_W'((x > y) ? (x - y) : (y - x));
  endfunction

  function automatic logic [R_W-1:0] ref_th(input int x, input int y);
    return R_W'((x + y) / 2);
  endfunction

  // Converter model: one-cycle registered latency.
  always @(posedge clk) begin
    if (conv_ena) begin
      conv_r     <= ref_r(int'(conv_x), int'(conv_y));
      conv_theta <= ref_th(int'(conv_x), int'(conv_y));
    end
  end

  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(model_ptr + off) % NREQ]) return (model_ptr + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int i, input int x, input int y);
    req_x[i*X_W +: X_W] = X_W'(x);
    req_y[i*Y_W +: Y_W] = Y_W'(y);
  endtask

  // Steps until rsp_valid is seen at a negedge (bounded); tallies enables and stray readies.
  task automatic wait_rsp(output bit ok, output int enas, output int bad_rdy);
    ok = 0;
    enas = 0;
    bad_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (conv_ena) enas++;
      if (busy && req_ready != '0) bad_rdy++;
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    bit ok;
    int enas, bad;
    int g;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_xy(i, i + 1, i);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if ({req_ready, conv_ena, conv_x, conv_y, rsp_valid, rsp_id, rsp_r, rsp_theta, busy} !== '0)
        begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: req_ready=%b conv_ena=%b rsp_valid=%b busy=%b, want all 0",
                 i, req_ready, conv_ena, rsp_valid, busy);
      end
    end
    step();
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    g = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g)) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want %b", req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    step();
    req_valid = '0;
    wait_rsp(ok, enas, bad);
    checks++;
    if (!ok || rsp_id !== IdW'(g)) begin
      errors++;
      $display("FAIL reset_first_rsp: ok=%0d id=%0d want id %0d", ok, rsp_id, g);
    end
    step();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    set_xy(2, 9, 3);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(model_pick(req_valid))) begin
      errors++;
      $display("FAIL single_grant: got %b want %b", req_ready, onehot(model_pick(req_valid)));
    end
    model_ptr = 3;
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (conv_ena !== 1'b1 || conv_x !== 4'd9 || conv_y !== 3'd3) begin
      errors++;
      $display("FAIL single_issue: ena=%b x=%0d y=%0d want 1 9 3", conv_ena, conv_x, conv_y);
    end
    step();
    @(negedge clk);
    checks++;
    if (conv_ena !== 1'b0 || rsp_valid !== 1'b0 || conv_x !== 4'd9) begin
      errors++;
      $display("FAIL single_wait: ena=%b rsp_valid=%b x=%0d want 0 0 9", conv_ena, rsp_valid, conv_x);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_r !== ref_r(9, 3) || rsp_theta !== ref_th(9, 3))
      begin
      errors++;
      $display("FAIL single_rsp: valid=%b id=%0d r=%0d th=%0d want 1 2 %0d %0d",
               rsp_valid, rsp_id, rsp_r, rsp_theta, ref_r(9, 3), ref_th(9, 3));
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
    end
    step();
  endtask

  task automatic test_round_robin();
    bit ok;
    int enas, bad;
    int g, ex, ey;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_xy(i, int'($urandom_range(15)), int'($urandom_range(7)));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      g = model_pick(req_valid);
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("FAIL rr_grant %0d: got %b want %b", n, req_ready, onehot(g));
      end
      ex = int'(req_x[g*X_W +: X_W]);
      ey = int'(req_y[g*Y_W +: Y_W]);
      model_ptr = (g + 1) % NREQ;
      step();
      set_xy(g, int'($urandom_range(15)), int'($urandom_range(7)));
      wait_rsp(ok, enas, bad);
      checks++;
      if (!ok || enas != 1 || bad != 0) begin
        errors++;
        $display("FAIL rr_flow %0d: rsp_seen=%0d enables=%0d stray_ready=%0d want 1 1 0",
                 n, ok, enas, bad);
      end
      checks++;
      if (rsp_id !== IdW'(g) || rsp_r !== ref_r(ex, ey) || rsp_theta !== ref_th(ex, ey)) begin
        errors++;
        $display("FAIL rr_rsp %0d: id=%0d r=%0d th=%0d want %0d %0d %0d", n, rsp_id, rsp_r,
                 rsp_theta, g, ref_r(ex, ey), ref_th(ex, ey));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int enas, bad;
    int g;
    req_valid = 4'b0010;
    set_xy(1, 2, 7);
    rsp_ready = 1'b0;
    @(negedge clk);
    g = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g)) begin
      errors++;
      $display("FAIL bp_grant: got %b want %b", req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    step();
    req_valid = '1;
    wait_rsp(ok, enas, bad);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_rsp_seen: rsp_valid never rose");
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_r !== ref_r(2, 7) || rsp_theta !== ref_th(2, 7) ||
          rsp_id !== IdW'(g) || conv_ena !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold %0d: valid=%b id=%0d r=%0d th=%0d ena=%b rdy=%b want 1 %0d %0d %0d 0 0",
                 i, rsp_valid, rsp_id, rsp_r, rsp_theta, conv_ena, req_ready, g, ref_r(2, 7),
                 ref_th(2, 7));
      end
      step();
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    g = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g)) begin
      errors++;
      $display("FAIL bp_next_grant: got %b want %b", req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    step();
    req_valid = '0;
    wait_rsp(ok, enas, bad);
    step();
  endtask

  task automatic test_wrap_skip();
    bit ok;
    int enas, bad;
    int g;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      g = model_pick(req_valid);
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("FAIL wrap_grant %0d: got %b want %b", n, req_ready, onehot(g));
      end
      model_ptr = (g + 1) % NREQ;
      step();
      wait_rsp(ok, enas, bad);
      checks++;
      if (!ok || rsp_id !== IdW'(g)) begin
        errors++;
        $display("FAIL wrap_rsp %0d: seen=%0d id=%0d want 1 %0d", n, ok, rsp_id, g);
      end
      step();
    end
    req_valid = '1;
    @(negedge clk);
    g = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g)) begin
      errors++;
      $display("FAIL wrap_ptr_end: got %b want %b", req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    step();
    req_valid = '0;
    wait_rsp(ok, enas, bad);
    step();
  endtask

  task automatic test_mid_reset();
    int seen;
    req_valid = 4'b0001;
    set_xy(0, 5, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(model_pick(req_valid))) begin
      errors++;
      $display("FAIL midrst_grant: got %b want %b", req_ready, onehot(model_pick(req_valid)));
    end
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || conv_ena !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_wait: busy=%b rsp_valid=%b ena=%b want 1 0 0", busy, rsp_valid,
               conv_ena);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_r !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL midrst_after: busy=%b rsp_valid=%b r=%0d rdy=%b want 0 0 0 0", busy,
               rsp_valid, rsp_r, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_rsp: %0d active cycles after abort, want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
